bnn_conv_pool: RTL and testbench

- Parametrised binary conv layer: 3x3 XNOR-popcount convolution, per-filter threshold, 2x2 max-pool (OR) over a latched binary image.
- Generalises the fixed 28x28 / 8-filter first layer:
  - image size, filter count and threshold width are parameters;
  - thresholds are per filter and runtime-loaded;
  - taps outside the image are masked;
  - results stream out one pooled bit per beat over valid/ready instead of a full output array.
- Sits between the image loader and the next layer; driven by the top-level state machine via start/done.

---
 rtl/bnn_conv_pool.sv | 172 +++++++++++++++++
 tb/tb_bnn_conv_pool.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_pool.sv
// bnn_conv_pool: binary 3x3 XNOR-popcount convolution with per-filter
// runtime thresholds and a 2x2 OR max-pool over a latched image. Results
// stream out one pooled bit per valid/ready beat, filter-major, column fastest.
// Optional feature macro: BNN_CONV_DBG_EN adds dbg_pop (max pop of the beat).
module bnn_conv_pool #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned NUM_F = 8,
  parameter int unsigned THR_W = 4,
  localparam int unsigned FW = (NUM_F > 1) ? $clog2(NUM_F) : 1,
  localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1,
  localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IMG_W*IMG_H-1:0]   pixels,
  input  logic [NUM_F*9-1:0]       weights,
  input  logic [NUM_F*THR_W-1:0]   thresholds,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  output logic [FW-1:0]            out_filt,
  output logic [RW-1:0]            out_row,
  output logic [CW-1:0]            out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
`ifdef BNN_CONV_DBG_EN
  ,
  output logic [3:0]               dbg_pop
`endif
);

  localparam int unsigned PH = IMG_H / 2;
  localparam int unsigned PW = IMG_W / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                   r_state;
  logic [IMG_W*IMG_H-1:0]   r_pix;
  logic [NUM_F*9-1:0]       r_w;
  logic [NUM_F*THR_W-1:0]   r_thr;
  logic [FW-1:0]            r_f;
  logic [RW-1:0]            r_pr;
  logic [CW-1:0]            r_pc;

  logic [8:0]               w_wsel;
  logic [THR_W-1:0]         w_thr;
  logic [3:0]               w_pop;
  logic [31:0]              w_rr;
  logic [31:0]              w_cc;
  logic                     w_bit;
  logic                     w_pc_wrap;
  logic                     w_pr_wrap;
  logic                     w_f_wrap;
  logic                     w_last;
`ifdef BNN_CONV_DBG_EN
  logic [3:0]               w_popmax;
`endif

  // Shift-based selects keep the variable-index muxes width-clean
  assign w_wsel    = 9'(r_w >> (32'(r_f) * 9));
  assign w_thr     = THR_W'(r_thr >> (32'(r_f) * THR_W));
  assign w_pc_wrap = (32'(r_pc) == PW - 1);
  assign w_pr_wrap = (32'(r_pr) == PH - 1);
  assign w_f_wrap  = (32'(r_f) == NUM_F - 1);
  assign w_last    = w_pc_wrap && w_pr_wrap && w_f_wrap;

  // Pooled result for the current (f,pr,pc): OR over the 2x2 window of pop>=thr.
  // Tap coordinates are kept offset by +1 so the image border test stays unsigned.
  always_comb begin
    w_bit = 1'b0;
    w_pop = '0;
    w_rr  = '0;
    w_cc  = '0;
`ifdef BNN_CONV_DBG_EN
    w_popmax = '0;
`endif
    for (int unsigned q = 0; q < 4; q++) begin
      w_pop = '0;
      for (int unsigned t = 0; t < 9; t++) begin
        w_rr = 2 * 32'(r_pr) + q / 2 + t / 3;
        w_cc = 2 * 32'(r_pc) + q % 2 + t % 3;
        if (w_rr >= 1 && w_rr <= IMG_H && w_cc >= 1 && w_cc <= IMG_W) begin
          if (1'(r_pix >> ((w_rr - 1) * IMG_W + (w_cc - 1))) == 1'(w_wsel >> t))
            w_pop = w_pop + 4'd1;
        end
      end
      if (32'(w_pop) >= 32'(w_thr))
        w_bit = 1'b1;
`ifdef BNN_CONV_DBG_EN
      if (w_pop > w_popmax)
        w_popmax = w_pop;
`endif
    end
  end

  // Run control, operand latching and the registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_f       <= '0;
      r_pr      <= '0;
      r_pc      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_filt  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BNN_CONV_DBG_EN
      dbg_pop   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_pix   <= pixels;
            r_w     <= weights;
            r_thr   <= thresholds;
            r_f     <= '0;
            r_pr    <= '0;
            r_pc    <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_valid && out_ready && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_FIN;
          end else if (!out_valid || out_ready) begin
            // Counters wrap on the final issue; the pending last beat blocks re-issue
            out_valid <= 1'b1;
            out_bit   <= w_bit;
            out_filt  <= r_f;
            out_row   <= r_pr;
            out_col   <= r_pc;
            out_last  <= w_last;
`ifdef BNN_CONV_DBG_EN
            dbg_pop   <= w_popmax;
`endif
            if (w_pc_wrap) begin
              r_pc <= '0;
              if (w_pr_wrap) begin
                r_pr <= '0;
                r_f  <= w_f_wrap ? '0 : r_f + 1'b1;
              end else begin
                r_pr <= r_pr + 1'b1;
              end
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_conv_pool.sv
// tb_bnn_conv_pool: scoreboard bench for bnn_conv_pool over three
// configurations (28x28/8 filters, 2x2/1 filter, 4x4/2 filters).
module tb_bnn_conv_pool;

  localparam int AW  = 28;
  localparam int AH  = 28;
  localparam int AF  = 8;
  localparam int ANB = AF * (AH / 2) * (AW / 2);

  typedef struct packed {
    logic       b;
    logic [7:0] f;
    logic [7:0] r;
    logic [7:0] c;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   passed;
  int   total;
  beat_t sb[$];

  // Configuration A: defaults
  logic               a_start, a_ready, a_valid, a_bit, a_last, a_busy, a_done;
  logic [AW*AH-1:0]   a_pix;
  logic [AF*9-1:0]    a_w;
  logic [AF*4-1:0]    a_thr;
  logic [2:0]         a_filt;
  logic [3:0]         a_row, a_col;
  // Configuration B: 2x2, one filter
  logic               b_start, b_ready, b_valid, b_bit, b_last, b_busy, b_done;
  logic [3:0]         b_pix;
  logic [8:0]         b_w;
  logic [3:0]         b_thr;
  logic               b_filt, b_row, b_col;
  // Configuration C: 4x4, two filters
  logic               c_start, c_ready, c_valid, c_bit, c_last, c_busy, c_done;
  logic [15:0]        c_pix;
  logic [17:0]        c_w;
  logic [7:0]         c_thr;
  logic               c_filt, c_row, c_col;
`ifdef BNN_CONV_DBG_EN
  logic [3:0]         a_dbg, b_dbg, c_dbg;
`endif

  bnn_conv_pool #(.IMG_W(AW), .IMG_H(AH), .NUM_F(AF), .THR_W(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .pixels(a_pix), .weights(a_w),
    .thresholds(a_thr), .out_valid(a_valid), .out_ready(a_ready), .out_bit(a_bit),
    .out_filt(a_filt), .out_row(a_row), .out_col(a_col), .out_last(a_last),
    .busy(a_busy), .done(a_done)
`ifdef BNN_CONV_DBG_EN
    , .dbg_pop(a_dbg)
`endif
  );

  bnn_conv_pool #(.IMG_W(2), .IMG_H(2), .NUM_F(1), .THR_W(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .pixels(b_pix), .weights(b_w),
    .thresholds(b_thr), .out_valid(b_valid), .out_ready(b_ready), .out_bit(b_bit),
    .out_filt(b_filt), .out_row(b_row), .out_col(b_col), .out_last(b_last),
    .busy(b_busy), .done(b_done)
`ifdef BNN_CONV_DBG_EN
    , .dbg_pop(b_dbg)
`endif
  );

  bnn_conv_pool #(.IMG_W(4), .IMG_H(4), .NUM_F(2), .THR_W(4)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .pixels(c_pix), .weights(c_w),
    .thresholds(c_thr), .out_valid(c_valid), .out_ready(c_ready), .out_bit(c_bit),
    .out_filt(c_filt), .out_row(c_row), .out_col(c_col), .out_last(c_last),
    .busy(c_busy), .done(c_done)
`ifdef BNN_CONV_DBG_EN
    , .dbg_pop(c_dbg)
`endif
  );

  // Reference: direct 3x3 correlation with border masking, then 2x2 OR
  function automatic logic model_a(input int f, input int pr, input int pc);
    logic       res;
    logic [3:0] thr;
    int         pop, r, c;
    res = 1'b0;
    thr = 4'(a_thr >> (f * 4));
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        pop = 0;
        for (int k = 0; k < 3; k++) begin
          for (int j = 0; j < 3; j++) begin
            r = 2 * pr + dr + k - 1;
            c = 2 * pc + dc + j - 1;
            if (r >= 0 && r < AH && c >= 0 && c < AW)
              if (1'(a_pix >> (r * AW + c)) == 1'(a_w >> (f * 9 + k * 3 + j)))
                pop++;
          end
        end
        if (pop >= int'(thr)) res = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic push_a;
    beat_t e;
    for (int f = 0; f < AF; f++)
      for (int pr = 0; pr < AH / 2; pr++)
        for (int pc = 0; pc < AW / 2; pc++) begin
          e.b    = model_a(f, pr, pc);
          e.f    = 8'(f);
          e.r    = 8'(pr);
          e.c    = 8'(pc);
          e.last = (f == AF - 1) && (pr == AH / 2 - 1) && (pc == AW / 2 - 1);
          sb.push_back(e);
        end
  endtask

  task automatic rand_a;
    for (int i = 0; i < 25; i++) a_pix = {a_pix[AW*AH-33:0], 32'($urandom)};
    for (int i = 0; i < 3; i++)  a_w   = {a_w[AF*9-33:0], 32'($urandom)};
    for (int i = 0; i < AF; i++) a_thr = {a_thr[AF*4-5:0], 4'($urandom_range(3, 7))};
  endtask

  // Waits (bounded) for a beat accepted at the next edge; returns after that edge
  task automatic next_a(output beat_t got, output bit ok);
    ok = 1'b0; got = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (a_valid && a_ready) begin
        got.b = a_bit; got.f = 8'(a_filt); got.r = 8'(a_row); got.c = 8'(a_col);
        got.last = a_last; ok = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic next_b(output beat_t got, output logic [3:0] dbg, output bit ok);
    ok = 1'b0; got = '0; dbg = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (b_valid && b_ready) begin
        got.b = b_bit; got.f = 8'(b_filt); got.r = 8'(b_row); got.c = 8'(b_col);
        got.last = b_last; ok = 1'b1;
`ifdef BNN_CONV_DBG_EN
        dbg = b_dbg;
`endif
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic next_c(output beat_t got, output bit ok);
    ok = 1'b0; got = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (c_valid && c_ready) begin
        got.b = c_bit; got.f = 8'(c_filt); got.r = 8'(c_row); got.c = 8'(c_col);
        got.last = c_last; ok = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({a_valid, a_busy, a_done, a_last, a_bit, a_filt, a_row, a_col} !== '0)
      $display("FAIL reset_a: got v=%b busy=%b done=%b last=%b bit=%b f=%0d r=%0d c=%0d, required all 0",
               a_valid, a_busy, a_done, a_last, a_bit, a_filt, a_row, a_col);
    else passed++;
    total++;
    if ({b_valid, b_busy, b_done, b_last, b_bit, b_filt, b_row, b_col} !== '0)
      $display("FAIL reset_b: got outputs %b, required all 0",
               {b_valid, b_busy, b_done, b_last, b_bit, b_filt, b_row, b_col});
    else passed++;
    total++;
    if ({c_valid, c_busy, c_done, c_last, c_bit, c_filt, c_row, c_col} !== '0)
      $display("FAIL reset_c: got outputs %b, required all 0",
               {c_valid, c_busy, c_done, c_last, c_bit, c_filt, c_row, c_col});
    else passed++;
  endtask

  task automatic test_full_run;
    beat_t got, exp; bit ok; int n, ones;
    a_pix = '1; a_w = '1; a_thr = {AF{4'd5}};
    push_a();
    a_ready = 1'b1; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    total++;
    if ({a_busy, a_valid} !== 2'b10) $display("FAIL full_start: got busy=%b valid=%b, required busy=1 valid=0", a_busy, a_valid);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (a_valid !== 1'b1) $display("FAIL full_latency: got valid=%b, required 1", a_valid);
    else passed++;
    n = 0; ones = 0;
    while (sb.size() > 0) begin
      next_a(got, ok);
      total++;
      if (!ok) begin
        $display("FAIL full_timeout: got no beat, required %0d more", sb.size());
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          $display("FAIL full_beat %0d: got b=%b f=%0d r=%0d c=%0d l=%b, required b=%b f=%0d r=%0d c=%0d l=%b",
                   n, got.b, got.f, got.r, got.c, got.last, exp.b, exp.f, exp.r, exp.c, exp.last);
        else passed++;
        n++;
        if (got.b) ones++;
      end
    end
    total++;
    if (ones !== ANB) $display("FAIL full_ones: got %0d one-beats, required %0d", ones, ANB);
    else passed++;
    total++;
    if ({a_done, a_busy, a_valid} !== 3'b100) $display("FAIL full_done: got done=%b busy=%b valid=%b, required 1 0 0", a_done, a_busy, a_valid);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({a_done, a_busy} !== 2'b00) $display("FAIL full_done_pulse: got done=%b busy=%b, required 0 0", a_done, a_busy);
    else passed++;
  endtask

  task automatic test_padding;
    beat_t got, exp; logic [3:0] dbg; bit ok;
    b_pix = '0; b_w = '0; b_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      b_thr = (t == 0) ? 4'd4 : 4'd5;
      exp = '0; exp.b = (t == 0); exp.last = 1'b1;
      sb.push_back(exp);
      b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
      next_b(got, dbg, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp)
        $display("FAIL padding_thr%0d: got ok=%b b=%b l=%b, required b=%b l=1", 4 + t, ok, got.b, got.last, exp.b);
      else passed++;
`ifdef BNN_CONV_DBG_EN
      total++;
      if (dbg !== 4'd4) $display("FAIL padding_dbg: got dbg_pop=%0d, required 4", dbg);
      else passed++;
`endif
      total++;
      if (b_done !== 1'b1) $display("FAIL padding_done: got done=%b, required 1", b_done);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  // Drains eight beats of configuration C against the scoreboard
  task automatic test_hot_pixel;
    beat_t got, exp; bit ok; logic [7:0] bits;
    c_pix = '0; c_pix[5] = 1'b1;
    c_w = '0; c_w[4] = 1'b1;
    c_thr = {4'd15, 4'd9};
    bits = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      exp.b = bits[0]; bits = bits >> 1;
      exp.f = 8'(i / 4); exp.r = 8'((i / 2) % 2); exp.c = 8'(i % 2); exp.last = (i == 7);
      sb.push_back(exp);
    end
    c_ready = 1'b1; c_start = 1'b1; @(posedge clk); #1; c_start = 1'b0;
    while (sb.size() > 0) begin
      next_c(got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp)
        $display("FAIL hot_pixel f%0d r%0d c%0d: got ok=%b b=%b f=%0d r=%0d c=%0d l=%b, required b=%b l=%b",
                 exp.f, exp.r, exp.c, ok, got.b, got.f, got.r, got.c, got.last, exp.b, exp.last);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_thresholds;
    beat_t got, exp; bit ok;
    c_pix = 16'($urandom); c_w = 18'($urandom);
    c_thr = {4'd15, 4'd0};
    for (int i = 0; i < 8; i++) begin
      exp.b = (i < 4); exp.f = 8'(i / 4); exp.r = 8'((i / 2) % 2); exp.c = 8'(i % 2);
      exp.last = (i == 7);
      sb.push_back(exp);
    end
    c_start = 1'b1; @(posedge clk); #1; c_start = 1'b0;
    while (sb.size() > 0) begin
      next_c(got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp)
        $display("FAIL thresholds f%0d r%0d c%0d: got ok=%b b=%b f=%0d r=%0d c=%0d, required b=%b",
                 exp.f, exp.r, exp.c, ok, got.b, got.f, got.r, got.c, exp.b);
      else passed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    beat_t got, exp; bit ok; int n; logic [13:0] snap;
    rand_a();
    push_a();
    a_ready = 1'b1; a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    n = 0;
    while (sb.size() > 0) begin
      next_a(got, ok);
      total++;
      if (!ok) begin
        $display("FAIL bp_timeout: got no beat, required %0d more", sb.size());
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          $display("FAIL bp_beat %0d: got b=%b f=%0d r=%0d c=%0d l=%b, required b=%b f=%0d r=%0d c=%0d l=%b",
                   n, got.b, got.f, got.r, got.c, got.last, exp.b, exp.f, exp.r, exp.c, exp.last);
        else passed++;
        n++;
        if (n == 100) begin
          a_ready = 1'b0;
          snap = {a_valid, a_bit, a_filt, a_row, a_col, a_last};
          for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            total++;
            if ({a_valid, a_bit, a_filt, a_row, a_col, a_last} !== snap || snap[13] !== 1'b1)
              $display("FAIL bp_stall cycle %0d: got %b, required %b with valid=1", s,
                       {a_valid, a_bit, a_filt, a_row, a_col, a_last}, snap);
            else passed++;
          end
          a_ready = 1'b1;
        end
      end
    end
    total++;
    if (n !== ANB) $display("FAIL bp_count: got %0d beats, required %0d", n, ANB);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_control;
    beat_t got, exp; bit ok; int n, seen;
    // Start pulsed mid-run with fresh inputs must not disturb the run
    rand_a();
    push_a();
    a_ready = 1'b1; a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    n = 0;
    while (sb.size() > 0) begin
      next_a(got, ok);
      total++;
      if (!ok) begin
        $display("FAIL ctl_timeout: got no beat, required %0d more", sb.size());
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          $display("FAIL ctl_beat %0d: got b=%b f=%0d r=%0d c=%0d l=%b, required b=%b f=%0d r=%0d c=%0d l=%b",
                   n, got.b, got.f, got.r, got.c, got.last, exp.b, exp.f, exp.r, exp.c, exp.last);
        else passed++;
        n++;
        if (n == 20) begin
          a_start = 1'b1; a_pix = ~a_pix; a_w = ~a_w; a_thr = ~a_thr;
        end
        if (n == 21) a_start = 1'b0;
      end
    end
    total++;
    if (n !== ANB) $display("FAIL ctl_count: got %0d beats, required %0d", n, ANB);
    else passed++;
    // Start during FIN is ignored
    a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({a_busy, a_valid} !== 2'b00) $display("FAIL ctl_fin_start: got busy=%b valid=%b, required 0 0", a_busy, a_valid);
    else passed++;
    // Reset mid-run aborts
    rand_a();
    a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    for (int i = 0; i < 30; i++) next_a(got, ok);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    total++;
    if ({a_valid, a_busy, a_done} !== 3'b000)
      $display("FAIL ctl_rst: got valid=%b busy=%b done=%b, required 0 0 0", a_valid, a_busy, a_done);
    else passed++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (a_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL ctl_rst_quiet: got %0d valid cycles, required 0", seen);
    else passed++;
    // Restart from (0,0,0)
    rand_a();
    push_a();
    a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    n = 0;
    while (sb.size() > 0) begin
      next_a(got, ok);
      total++;
      if (!ok) begin
        $display("FAIL restart_timeout: got no beat, required %0d more", sb.size());
        sb.delete();
      end else begin
        exp = sb.pop_front();
        if (got !== exp)
          $display("FAIL restart_beat %0d: got b=%b f=%0d r=%0d c=%0d l=%b, required b=%b f=%0d r=%0d c=%0d l=%b",
                   n, got.b, got.f, got.r, got.c, got.last, exp.b, exp.f, exp.r, exp.c, exp.last);
        else passed++;
        n++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    passed = 0; total = 0;
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1; a_pix = '0; a_w = '0; a_thr = '0;
    b_start = 1'b0; b_ready = 1'b1; b_pix = '0; b_w = '0; b_thr = '0;
    c_start = 1'b0; c_ready = 1'b1; c_pix = '0; c_w = '0; c_thr = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_full_run();
    test_padding();
    test_hot_pixel();
    test_thresholds();
    test_backpressure();
    test_control();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
